// File: rtl/rsp_s2_prep_dcest_mc.sv
// DC estimator: accumulates lane sums over a frame block, then scales and shifts to a per-block DC value.
// Optional macro RSP_S2_DCEST_SAT_EN saturates the result; otherwise the low DATA_WIDTH bits are kept.
module rsp_s2_prep_dcest_mc #(
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int SCALE_WIDTH = 17
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [12:0]                   cfg_smp_cnt,
    input  logic [9:0]                    cfg_chp_cnt,
    input  logic [3:0]                    cfg_frm_cnt,
    input  logic [SCALE_WIDTH-1:0]        cfg_scale,
    input  logic [5:0]                    cfg_shift,
    input  logic                          cfg_is_real,
    input  logic [LANES*2*DATA_WIDTH-1:0] i_data,
    input  logic                          i_valid,
    input  logic                          i_last,
    output logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_dc_i,
    output logic [DATA_WIDTH-1:0]         o_dc_q,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic                          o_busy,
    output logic                          o_err
);
    localparam int PW     = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {IDLE, ACC, MUL, OUT} state_t;
    state_t state, state_nx;

    logic [26:0]                  cnt, e_last;
    logic [27:0]                  e_tot;
    logic [SCALE_WIDTH-1:0]       scale;
    logic [5:0]                   shift;
    logic [6:0]                   sh_amt;
    logic                         is_real, beat, last, tree_vld;
    logic [STAGES:0]              vld_pipe;
    logic signed [ACC_WIDTH-1:0]  sum_i, sum_q, tree_i, tree_q, acc_i, acc_q;
    logic signed [PW-1:0]         prod_i, prod_q, sh_i, sh_q;
    logic [DATA_WIDTH-1:0]        fit_i, fit_q, res_i, res_q;

    assign beat    = i_valid && (state == ACC);
    assign last    = (cnt == e_last);
    assign i_ready = (state == ACC);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == OUT);
    assign sh_amt  = 7'd16 + {1'b0, shift};
    assign e_tot   = (28'(cfg_smp_cnt) + 28'd1) * (28'(cfg_chp_cnt) + 28'd1)
                   * (28'(cfg_frm_cnt) + 28'd1);

    // In real mode the Q halves are just more real samples folded into acc_i.
    always_comb begin
        sum_i = '0;
        sum_q = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_i = sum_i + ACC_WIDTH'($signed(i_data[2*k*DATA_WIDTH +: DATA_WIDTH]));
            if (is_real)
                sum_i = sum_i + ACC_WIDTH'($signed(i_data[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]));
            else
                sum_q = sum_q + ACC_WIDTH'($signed(i_data[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

`ifdef RSP_S2_DCEST_SAT_EN
    localparam logic signed [PW-1:0] SMAX = PW'((2**(DATA_WIDTH-1)) - 1);
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    function automatic logic [DATA_WIDTH-1:0] fit(input logic signed [PW-1:0] v);
        if (v > SMAX)      fit = SMAX[DATA_WIDTH-1:0];
        else if (v < SMIN) fit = SMIN[DATA_WIDTH-1:0];
        else               fit = v[DATA_WIDTH-1:0];
    endfunction

    assign fit_i = fit(sh_i);
    assign fit_q = fit(sh_q);
`else
    logic unused_hi;
    assign fit_i     = sh_i[DATA_WIDTH-1:0];
    assign fit_q     = sh_q[DATA_WIDTH-1:0];
    assign unused_hi = ^{sh_i[PW-1:DATA_WIDTH], sh_q[PW-1:DATA_WIDTH]};
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_start) state_nx = ACC;
            ACC:     if (beat && last) state_nx = MUL;
            MUL:     if (vld_pipe[STAGES]) state_nx = OUT;
            OUT:     if (o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pipe: tree (edge 0), acc (1), multiply (2), shift (3), fit (4), output load (6).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            e_last   <= '0;
            scale    <= '0;
            shift    <= '0;
            is_real  <= 1'b0;
            tree_vld <= 1'b0;
            vld_pipe <= '0;
            tree_i   <= '0;
            tree_q   <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
            prod_i   <= '0;
            prod_q   <= '0;
            sh_i     <= '0;
            sh_q     <= '0;
            res_i    <= '0;
            res_q    <= '0;
            o_dc_i   <= '0;
            o_dc_q   <= '0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            tree_vld <= beat;
            vld_pipe <= {vld_pipe[STAGES-1:0], beat && last};
            o_err    <= beat && (i_last != last);
            if (beat) begin
                tree_i <= sum_i;
                tree_q <= sum_q;
                if (!last) cnt <= cnt + 27'd1;
            end
            if (state == IDLE && i_start) begin
                e_last  <= 27'(e_tot - 28'd1);
                scale   <= cfg_scale;
                shift   <= cfg_shift;
                is_real <= cfg_is_real;
                cnt     <= '0;
                acc_i   <= '0;
                acc_q   <= '0;
            end else if (tree_vld) begin
                acc_i <= acc_i + tree_i;
                acc_q <= acc_q + tree_q;
            end
            prod_i <= acc_i * $signed({1'b0, scale});
            prod_q <= acc_q * $signed({1'b0, scale});
            sh_i   <= prod_i >>> sh_amt;
            sh_q   <= prod_q >>> sh_amt;
            res_i  <= fit_i;
            res_q  <= fit_q;
            if (vld_pipe[STAGES]) begin
                o_dc_i <= res_i;
                o_dc_q <= res_q;
            end
        end
    end
endmodule

// File: tb/tb_rsp_s2_prep_dcest_mc.sv
// Directed bench for rsp_s2_prep_dcest_mc: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_rsp_s2_prep_dcest_mc;
    localparam int LANES = 4;
    localparam int DW    = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    i_start = 1'b0;
    logic [12:0]             cfg_smp_cnt = '0;
    logic [9:0]              cfg_chp_cnt = '0;
    logic [3:0]              cfg_frm_cnt = '0;
    logic [16:0]             cfg_scale = '0;
    logic [5:0]              cfg_shift = '0;
    logic                    cfg_is_real = 1'b0;
    logic [LANES*2*DW-1:0]   i_data = '0;
    logic                    i_valid = 1'b0;
    logic                    i_last = 1'b0;
    logic                    i_ready;
    logic [DW-1:0]           o_dc_i, o_dc_q;
    logic                    o_valid;
    logic                    o_ready = 1'b1;
    logic                    o_busy, o_err;

    rsp_s2_prep_dcest_mc #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(48), .SCALE_WIDTH(17)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .cfg_smp_cnt(cfg_smp_cnt), .cfg_chp_cnt(cfg_chp_cnt), .cfg_frm_cnt(cfg_frm_cnt),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_is_real(cfg_is_real),
        .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready),
        .o_dc_i(o_dc_i), .o_dc_q(o_dc_q), .o_valid(o_valid), .o_ready(o_ready),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        int unsigned          c;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: records o_valid rise cycle, checks value and latency on each handshake.
    logic        vprev = 1'b0;
    int unsigned rise  = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            vprev = 1'b0;
        end else begin
            if (o_valid && !vprev) rise = cyc;
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dc_i", $signed(o_dc_i), e.i);
                    chk("dc_q", $signed(o_dc_q), e.q);
                    chk("latency", rise, e.c);
                end
            end
            vprev = o_valid;
        end
    end

    task automatic start(input logic [12:0] smp, input logic [9:0] chp, input logic [3:0] frm,
                         input logic rl, input logic [16:0] sc, input logic [5:0] sh);
        cfg_smp_cnt = smp; cfg_chp_cnt = chp; cfg_frm_cnt = frm;
        cfg_is_real = rl;  cfg_scale = sc;   cfg_shift = sh;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic set_beat(input logic signed [DW-1:0] vi, input logic signed [DW-1:0] vq);
        for (int k = 0; k < LANES; k++) begin
            i_data[2*k*DW +: DW]     = vi;
            i_data[(2*k+1)*DW +: DW] = vq;
        end
    endtask

    task automatic run(input logic [12:0] smp, input logic [9:0] chp, input logic [3:0] frm,
                       input logic rl, input logic [16:0] sc, input logic [5:0] sh,
                       input logic signed [DW-1:0] vi, input logic signed [DW-1:0] vq,
                       input int last_at, input logic signed [DW-1:0] ei, input logic signed [DW-1:0] eq);
        int n;
        n = (int'(smp) + 1) * (int'(chp) + 1) * (int'(frm) + 1);
        start(smp, chp, frm, rl, sc, sh);
        for (int b = 0; b < n; b++) begin
            set_beat(vi, vq);
            i_valid = 1'b1;
            i_last  = (b == last_at || (last_at < 0 && b == n - 1));
            chk("i_ready", i_ready, 1);
            @(posedge clk); #1;
            chk("o_err", o_err, (last_at >= 0) && ((b == last_at) != (b == n - 1)));
            if (b == n - 1) sb.push_back('{ei, eq, cyc + 6});
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_dc_i", o_dc_i, 0);
        chk("rst_dc_q", o_dc_q, 0);
        chk("rst_ready", i_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic complex average
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd4, 16'sd100, -16'sd50, -1, 16'sd100, -16'sd50);
        wait_idle();
        // real mode, half scale
        run(13'd1, 10'd0, 4'd0, 1'b1, 17'd32768, 6'd3, 16'sd16, 16'sd16, -1, 16'sd16, 16'sd0);
        wait_idle();
        // full-scale positive: saturates or wraps
`ifdef RSP_S2_DCEST_SAT_EN
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd0, 16'sd32767, 16'sd0, -1, 16'sd32767, 16'sd0);
`else
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd0, 16'sd32767, 16'sd0, -1, -16'sd16, 16'sd0);
`endif
        wait_idle();
        // E=1, floor rounding: -12/8 -> -2, 20/8 -> 2
        run(13'd0, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd3, -16'sd3, 16'sd5, -1, -16'sd2, 16'sd2);
        wait_idle();
        // E=8 across all three dimensions, scale 1.5
        run(13'd1, 10'd1, 4'd1, 1'b0, 17'd98304, 6'd1, 16'sd1, -16'sd1, -1, 16'sd24, -16'sd24);
        wait_idle();
        // early i_last on beat 2: error on beats 2 and 4, result still produced
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd2, 16'sd10, 16'sd20, 1, 16'sd40, 16'sd80);
        wait_idle();

        // stall at OUT for 10 cycles; i_start must be ignored
        o_ready = 1'b0;
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd4, -16'sd7, 16'sd7, -1, -16'sd7, 16'sd7);
        begin
            int t = 0;
            while (!o_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("stall_valid", o_valid, 1);
        for (int k = 0; k < 10; k++) begin
            i_start = (k == 3);
            @(posedge clk); #1;
            chk("stall_hold_valid", o_valid, 1);
            chk("stall_hold_i", $signed(o_dc_i), -7);
            chk("stall_hold_q", $signed(o_dc_q), 7);
            chk("stall_ready", i_ready, 0);
        end
        i_start = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_idle", o_busy, 0);

        // reset during beat 2 of 4, then a clean run
        start(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd4);
        set_beat(16'sd1000, 16'sd1000);
        i_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_valid, 0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", o_valid, 0);
        end
        run(13'd3, 10'd0, 4'd0, 1'b0, 17'd65536, 6'd4, 16'sd200, -16'sd200, -1, 16'sd200, -16'sd200);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
